rtc_bus_scheduler: RTL
======================

Name: rtc_bus_scheduler

Overview:
Arbitrates the RTC parallel bus between three sequencers: initialisation, time/date write, and periodic read. It grants one requester at a time and generates the shared bus-phase counter cont_escritura that each sequencer uses to place its address and data bytes. It muxes the granted sequencer's byte onto the bus and clears the sequencer's listo flag when its transaction ends. It sits between the main FSM or requesters and the RTC bus-timing block.

Parameters:
END_PHASE, 42, last value of cont_escritura in one bus round; the counter counts 0..END_PHASE.
MAX_ROUNDS, 8, number of full counter rounds allowed per grant before timeout (used only with TIMEOUT_EN).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_inicio  in  1  initialisation sequencer requests the bus
req_escritura  in  1  write sequencer requests the bus
req_lectura  in  1  read sequencer requests the bus
listo_inicio  in  1  initialisation sequencer is finished
listo_escritura  in  1  write sequencer is finished
listo_lectura  in  1  read sequencer is finished
bus_in_inicio  in  8  byte from the initialisation sequencer
bus_in_escritura  in  8  byte from the write sequencer
enable_inicio  out  1  grant to the initialisation sequencer
enable_escritura  out  1  grant to the write sequencer
enable_lectura  out  1  grant to the read sequencer
reset_listo_inicio  out  1  one-cycle clear pulse to the initialisation sequencer
reset_listo_escritura  out  1  one-cycle clear pulse to the write sequencer
reset_listo_lectura  out  1  one-cycle clear pulse to the read sequencer
cont_escritura  out  6  bus-phase counter
bus_out  out  8  byte driven to the bus-timing block
bus_dir  out  1  1 = write transaction (inicio or escritura), 0 = read
error_timeout  out  1  one-cycle pulse when a grant is aborted

Behaviour:
- Reset clears state to IDLE; all enables, pulses, cont_escritura, bus_out, bus_dir and error_timeout read 0. Reset wins over every other event, including mid-transaction.
- States:
  - IDLE: cont_escritura = 0.
  - GRANT: exactly one enable is high.
  - RELEASE: lasts one cycle.
- Arbitration happens in IDLE only. Fixed priority: inicio > escritura > lectura.
  - If any req is sampled high at edge n, then from edge n+1 the state is GRANT, the winner's enable = 1 and cont_escritura = 0.
- In GRANT:
  - cont_escritura increments by 1 each cycle and wraps END_PHASE -> 0.
  - A req deasserting does not abort the grant.
  - listo from a non-granted sequencer is ignored.
- If the granted listo is sampled high, the next cycle is RELEASE:
  - enable drops and cont_escritura = 0.
  - The matching reset_listo_* = 1 for that cycle only.
  - The state then returns to IDLE.
- Turnaround: at least one IDLE cycle separates RELEASE and the next GRANT. Minimum gap between grants is 2 cycles.
- bus_out is combinational from the registered grant:
  - bus_in_inicio when inicio is granted.
  - bus_in_escritura when escritura is granted.
  - 8'h00 otherwise, including read grants.
- bus_dir = 1 while inicio or escritura is granted; 0 otherwise.
- listo arriving at cont_escritura == END_PHASE behaves normally: RELEASE follows and the counter goes to 0.
- A req that stays high through RELEASE is re-arbitrated in IDLE. There is no fairness beyond fixed priority; a continuously requesting inicio starves the others.

Optional Feature:
RTC_SCHED_TIMEOUT_EN:
- When defined, a round counter (width covering MAX_ROUNDS) counts wraps of cont_escritura during a grant.
- When it reaches MAX_ROUNDS with no listo, the next cycle is RELEASE with the normal reset_listo pulse, and error_timeout = 1 for that cycle.
- If listo and the timeout condition occur in the same cycle, listo wins and error_timeout stays 0.
- When not defined, there is no round counter, error_timeout is tied 0, and a grant waits for listo indefinitely.

Decomposition:
- Shared package rtc_pkg holds:
  - The state enum (IDLE, GRANT, RELEASE).
  - Requester ID constants (REQ_INICIO = 0, REQ_ESCRITURA = 1, REQ_LECTURA = 2).
  - The default END_PHASE and the phase constants ADDR_PHASE = 7 and DATA_PHASE = 29 used by the sequencers.
- One natural sub-module, rtc_phase_counter: the 0..END_PHASE counter with clear/enable and a wrap pulse; the wrap pulse feeds the timeout round counter.

Test Plan:
- reset high for 3 cycles, then req_inicio = 1 -> all outputs 0 during reset; enable_inicio = 1 one cycle after sampling; cont_escritura counts 0,1,...,42,0; bus_out follows bus_in_inicio; bus_dir = 1.
- req_inicio, req_escritura and req_lectura rise in the same cycle -> enable_inicio first. After listo_inicio: reset_listo_inicio pulse, one IDLE cycle, then enable_escritura. Lectura is granted last, with bus_out = 8'h00 and bus_dir = 0.
- listo_inicio asserted exactly at cont_escritura = 42 -> the next cycle shows reset_listo_inicio = 1 and cont_escritura = 0, followed by IDLE.
- During an escritura grant, pulse listo_lectura and drop req_escritura -> the grant continues; no reset_listo_lectura pulse.
- Assert reset at cont_escritura = 20 during a grant -> the next cycle shows all enables 0, counter 0, and no reset_listo pulse.
- With RTC_SCHED_TIMEOUT_EN and MAX_ROUNDS = 2, grant escritura and never assert listo -> after 2 wraps (86 cycles): error_timeout and reset_listo_escritura pulse together for 1 cycle. Without the macro, the grant persists beyond 200 cycles.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus scheduler slice.
//   - sched_state_t : scheduler states (IDLE, GRANT, RELEASE)
//   - REQ_*         : requester IDs used as the registered grant index
//   - END_PHASE_DEFAULT, ADDR_PHASE, DATA_PHASE : bus-phase constants that
//     the sequencers use to place their address and data bytes
//   - pick_winner   : fixed-priority arbitration (inicio > escritura > lectura)
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

  localparam logic [1:0] REQ_INICIO    = 2'd0;
  localparam logic [1:0] REQ_ESCRITURA = 2'd1;
  localparam logic [1:0] REQ_LECTURA   = 2'd2;

  localparam int PHASE_W           = 6;
  localparam int END_PHASE_DEFAULT = 42;
  localparam int ADDR_PHASE        = 7;
  localparam int DATA_PHASE        = 29;

  // Only meaningful when at least one request is high; the caller guards it.
  function automatic logic [1:0] pick_winner(input logic ini, input logic esc);
    if (ini)      return REQ_INICIO;
    else if (esc) return REQ_ESCRITURA;
    else          return REQ_LECTURA;
  endfunction

endpackage

// File: rtl/rtc_phase_counter.sv
// rtc_phase_counter: bus-phase counter running 0..END_PHASE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force count to 0 (has priority over enable)
//   enable     : advance count by one, wrapping END_PHASE -> 0
//   count      : current phase
//   wrap       : high in the cycle where an enabled count sits at END_PHASE
module rtc_phase_counter
  import rtc_pkg::*;
#(
  parameter int END_PHASE = END_PHASE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [PHASE_W-1:0] count,
  output logic               wrap
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(END_PHASE);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign wrap = enable && (count == LAST);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: grants the RTC parallel bus to one of three sequencers
// (initialisation, time/date write, periodic read), drives the shared phase
// counter cont_escritura, muxes the granted byte onto bus_out and pulses the
// matching reset_listo_* when the transaction ends.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_*                      : bus requests from the three sequencers
//   listo_*                    : done flags from the three sequencers
//   bus_in_inicio/escritura    : bytes from the two writing sequencers
//   enable_*                   : one-hot grant (only in GRANT)
//   reset_listo_*              : one-cycle clear pulse (only in RELEASE)
//   cont_escritura             : bus-phase counter
//   bus_out, bus_dir           : granted byte and direction (1 = write)
//   error_timeout              : one-cycle pulse when a grant is aborted
// Optional feature: define RTC_SCHED_TIMEOUT_EN to abort a grant after
// MAX_ROUNDS full counter rounds without listo.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int END_PHASE  = END_PHASE_DEFAULT,
  parameter int MAX_ROUNDS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_inicio,
  input  logic       req_escritura,
  input  logic       req_lectura,
  input  logic       listo_inicio,
  input  logic       listo_escritura,
  input  logic       listo_lectura,
  input  logic [7:0] bus_in_inicio,
  input  logic [7:0] bus_in_escritura,
  output logic       enable_inicio,
  output logic       enable_escritura,
  output logic       enable_lectura,
  output logic       reset_listo_inicio,
  output logic       reset_listo_escritura,
  output logic       reset_listo_lectura,
  output logic [5:0] cont_escritura,
  output logic [7:0] bus_out,
  output logic       bus_dir,
  output logic       error_timeout
);

  sched_state_t state, state_next;
  logic [1:0]   grant_id;
  logic         any_req;
  logic         listo_granted;
  logic         wrap;
  logic         timeout_hit;
  logic         timeout_q;

  assign any_req = req_inicio | req_escritura | req_lectura;

  // Only the granted sequencer's listo can end a grant.
  always_comb begin
    listo_granted = 1'b0;
    case (grant_id)
      REQ_INICIO:    listo_granted = listo_inicio;
      REQ_ESCRITURA: listo_granted = listo_escritura;
      REQ_LECTURA:   listo_granted = listo_lectura;
      default:       listo_granted = 1'b0;
    endcase
  end

  // Counter is held at 0 outside GRANT and on the edge that leaves GRANT,
  // so it reads 0 in IDLE, on the first GRANT cycle and in RELEASE.
  rtc_phase_counter #(
    .END_PHASE(END_PHASE)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clear (state_next != GRANT),
    .enable(state == GRANT),
    .count (cont_escritura),
    .wrap  (wrap)
  );

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int ROUND_W = $clog2(MAX_ROUNDS + 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);
  logic [ROUND_W-1:0] rounds;

  // Counts completed counter rounds within the current grant; the wrap that
  // would make it reach MAX_ROUNDS is the timeout event.
  always_ff @(posedge clk) begin
    if (reset || state != GRANT) begin
      rounds <= '0;
    end else if (wrap) begin
      rounds <= rounds + 1'b1;
    end
  end

  assign timeout_hit = (state == GRANT) && wrap && (rounds == LAST_ROUND);
`else
  // wrap and MAX_ROUNDS have no consumer without the timeout feature.
  logic timeout_unused;
  assign timeout_unused = wrap ^ (MAX_ROUNDS > 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register; the grant index is latched when arbitration happens and
  // held through RELEASE so the right reset_listo pulse can be produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= REQ_INICIO;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        grant_id <= pick_winner(req_inicio, req_escritura);
      end
      // listo has priority, so a simultaneous listo suppresses the error.
      timeout_q <= (state == GRANT) && timeout_hit && !listo_granted;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   if (listo_granted || timeout_hit) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enable_inicio         = 1'b0;
    enable_escritura      = 1'b0;
    enable_lectura        = 1'b0;
    reset_listo_inicio    = 1'b0;
    reset_listo_escritura = 1'b0;
    reset_listo_lectura   = 1'b0;
    bus_out               = 8'h00;
    bus_dir               = 1'b0;
    error_timeout         = 1'b0;
    case (state)
      GRANT: begin
        case (grant_id)
          REQ_INICIO: begin
            enable_inicio = 1'b1;
            bus_out       = bus_in_inicio;
            bus_dir       = 1'b1;
          end
          REQ_ESCRITURA: begin
            enable_escritura = 1'b1;
            bus_out          = bus_in_escritura;
            bus_dir          = 1'b1;
          end
          default: enable_lectura = 1'b1;
        endcase
      end
      RELEASE: begin
        error_timeout = timeout_q;
        case (grant_id)
          REQ_INICIO:    reset_listo_inicio    = 1'b1;
          REQ_ESCRITURA: reset_listo_escritura = 1'b1;
          default:       reset_listo_lectura   = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule
